ysyx_2022040010_hazard_ctrl: RTL and testbench

Parametrised pipeline hazard controller for the ysyx_2022040010 in-order core. Combines load-use, execute-busy and memory-busy stall requests with branch/jump redirects. Drives per-stage stall and flush vectors plus the fetch redirect. Holds a redirect that arrives while fetch is frozen, and flags a stall watchdog timeout.

---
 rtl/ysyx_2022040010_hazard_ctrl.sv | 129 ++++++++++++
 tb/tb_ysyx_2022040010_hazard_ctrl.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/ysyx_2022040010_hazard_ctrl.sv
// Pipeline hazard controller: prioritised stall masks, redirect flush/defer, stall watchdog.
// Optional HAZARD_PERF_EN builds the stall/redirect performance counters.
module ysyx_2022040010_hazard_ctrl #(
    parameter int STAGES    = 5,
    parameter int PC_W      = 32,
    parameter int STALL_TMO = 1023
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              stallreq_for_load,
    input  logic              stallreq_for_ex,
    input  logic              stallreq_for_mem,
    input  logic              redirect_valid,
    input  logic [PC_W-1:0]   redirect_pc,
    output logic [STAGES-1:0] stall,
    output logic [STAGES-1:0] flush,
    output logic              pc_redirect,
    output logic [PC_W-1:0]   new_pc,
    output logic              stall_timeout,
    output logic [31:0]       perf_stall_cnt,
    output logic [31:0]       perf_flush_cnt
);
    // state | meaning
    // IDLE  | no redirect waiting for fetch
    // PEND  | redirect captured in pend_pc, issued on first unstalled cycle
    typedef enum logic {IDLE = 1'b0, PEND = 1'b1} state_t;

    localparam int            TW      = $clog2(STALL_TMO + 1);
    localparam logic [TW-1:0] TMO_MAX = TW'(STALL_TMO);

    state_t          state, state_nxt;
    logic [PC_W-1:0] pend_pc, pend_pc_nxt;
    logic            pend_vld;
    logic            load_eff;
    logic            stall_if;
    int              stall_len;
    logic [TW-1:0]   tmo_cnt, tmo_nxt;

    assign pend_vld = (state == PEND);
    // the ID instruction behind a load-use hazard is being flushed, so its request is moot
    assign load_eff = stallreq_for_load & ~redirect_valid & ~pend_vld;
    assign stall_if = stallreq_for_mem | stallreq_for_ex | load_eff;

    always_comb begin
        stall_len = 0;
        if (stallreq_for_mem)     stall_len = 4;
        else if (stallreq_for_ex) stall_len = 3;
        else if (load_eff)        stall_len = 2;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            pend_pc <= '0;
        end else begin
            state   <= state_nxt;
            pend_pc <= pend_pc_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        pend_pc_nxt = pend_pc;
        if (redirect_valid && stall_if) begin
            state_nxt   = PEND;
            pend_pc_nxt = redirect_pc;
        end else if (!stall_if) begin
            state_nxt = IDLE;
        end
    end

    always_comb begin
        stall       = '0;
        flush       = '0;
        pc_redirect = 1'b0;
        new_pc      = '0;
        if (rst_n) begin
            for (int i = 0; i < STAGES; i++) begin
                stall[i] = (i < stall_len);
                flush[i] = (stall_len != 0) && (i == stall_len);
            end
            if (redirect_valid) begin
                flush[0] = 1'b1;
                flush[1] = 1'b1;
            end
            if (redirect_valid && !stall_if) begin
                pc_redirect = 1'b1;
                new_pc      = redirect_pc;
            end else if (pend_vld && !stall_if) begin
                pc_redirect = 1'b1;
                new_pc      = pend_pc;
                flush[0]    = 1'b1;
                flush[1]    = 1'b1;
            end
        end
    end

    always_comb begin
        if (!stall_if)              tmo_nxt = '0;
        else if (tmo_cnt == TMO_MAX) tmo_nxt = tmo_cnt;
        else                        tmo_nxt = tmo_cnt + TW'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmo_cnt       <= '0;
            stall_timeout <= 1'b0;
        end else begin
            tmo_cnt <= tmo_nxt;
            if (tmo_nxt == TMO_MAX) stall_timeout <= 1'b1;
        end
    end

`ifdef HAZARD_PERF_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_stall_cnt <= '0;
            perf_flush_cnt <= '0;
        end else begin
            if (stall_if)    perf_stall_cnt <= perf_stall_cnt + 32'd1;
            if (pc_redirect) perf_flush_cnt <= perf_flush_cnt + 32'd1;
        end
    end
`else
    assign perf_stall_cnt = '0;
    assign perf_flush_cnt = '0;
`endif

endmodule

// File: tb/tb_ysyx_2022040010_hazard_ctrl.sv
// Directed bench for ysyx_2022040010_hazard_ctrl (STALL_TMO=8); perf expectations follow HAZARD_PERF_EN.
module tb_ysyx_2022040010_hazard_ctrl;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        ld, ex, mem, rv;
    logic [31:0] rpc;
    logic [4:0]  stall, flush;
    logic        pc_redirect, stall_timeout;
    logic [31:0] new_pc, perf_stall_cnt, perf_flush_cnt;
    int          n_chk  = 0;
    int          n_pass = 0;

    ysyx_2022040010_hazard_ctrl #(.STAGES(5), .PC_W(32), .STALL_TMO(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .stallreq_for_load(ld), .stallreq_for_ex(ex), .stallreq_for_mem(mem),
        .redirect_valid(rv), .redirect_pc(rpc),
        .stall(stall), .flush(flush), .pc_redirect(pc_redirect), .new_pc(new_pc),
        .stall_timeout(stall_timeout),
        .perf_stall_cnt(perf_stall_cnt), .perf_flush_cnt(perf_flush_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic l, input logic e, input logic m, input logic r, input logic [31:0] pc);
        ld = l; ex = e; mem = m; rv = r; rpc = pc;
        #1;
    endtask

    task automatic do_reset();
        drive(0, 0, 0, 0, 0);
        rst_n = 1'b0;
        #3;
        rst_n = 1'b1;
        cyc();
    endtask

    task automatic out_chk(input string tag, input logic [4:0] s, input logic [4:0] f,
                           input logic pr, input logic [31:0] pc);
        chk({tag, ".stall"}, 64'(stall), 64'(s));
        chk({tag, ".flush"}, 64'(flush), 64'(f));
        chk({tag, ".pc_redirect"}, 64'(pc_redirect), 64'(pr));
        chk({tag, ".new_pc"}, 64'(new_pc), 64'(pc));
    endtask

    initial begin
        rst_n = 1'b0;
        drive(1, 1, 1, 1, 32'hFFFF_FFFF);
        cyc();
        cyc();
        out_chk("rst_hold", 5'b0, 5'b0, 0, 0);
        chk("rst_hold.tmo", 64'(stall_timeout), 0);
        chk("rst_hold.pstall", 64'(perf_stall_cnt), 0);
        chk("rst_hold.pflush", 64'(perf_flush_cnt), 0);
        drive(0, 0, 0, 0, 0);
        rst_n = 1'b1;
        cyc();
        out_chk("rst_rel", 5'b0, 5'b0, 0, 0);

        // priority of simultaneous requests
        drive(1, 1, 1, 0, 0);
        out_chk("prio_all", 5'b01111, 5'b10000, 0, 0);
        drive(1, 1, 0, 0, 0);
        out_chk("prio_ex", 5'b00111, 5'b01000, 0, 0);
        drive(1, 0, 0, 0, 0);
        out_chk("prio_ld", 5'b00011, 5'b00100, 0, 0);
        cyc();

        // immediate redirect, concurrent load request ignored
        do_reset();
        drive(1, 0, 0, 1, 32'h8000_0040);
        out_chk("imm", 5'b00000, 5'b00011, 1, 32'h8000_0040);
        cyc();
        drive(0, 0, 0, 0, 32'h8000_0040);
        out_chk("imm_after", 5'b0, 5'b0, 0, 0);

        // deferred redirect across a 3-cycle mem stall
        do_reset();
        drive(0, 0, 1, 1, 32'h8000_1000);
        out_chk("def_c1", 5'b01111, 5'b10011, 0, 0);
        cyc();
        drive(0, 0, 1, 0, 0);
        out_chk("def_c2", 5'b01111, 5'b10000, 0, 0);
        cyc();
        drive(0, 0, 1, 0, 0);
        out_chk("def_c3", 5'b01111, 5'b10000, 0, 0);
        cyc();
        drive(0, 0, 0, 0, 0);
        out_chk("def_c4", 5'b00000, 5'b00011, 1, 32'h8000_1000);
        cyc();
        out_chk("def_c5", 5'b0, 5'b0, 0, 0);

        // youngest redirect replaces the pending one; load ignored while pending
        do_reset();
        drive(0, 0, 1, 1, 32'h8000_1000);
        cyc();
        drive(0, 0, 1, 1, 32'h8000_2000);
        out_chk("ovr_c2", 5'b01111, 5'b10011, 0, 0);
        cyc();
        drive(0, 0, 1, 0, 0);
        cyc();
        drive(1, 0, 0, 0, 0);
        out_chk("ovr_c4", 5'b00000, 5'b00011, 1, 32'h8000_2000);
        cyc();
        out_chk("ovr_c5_ld", 5'b00011, 5'b00100, 0, 0);

        // unstalled redirect in PEND wins over pend_pc, state returns to IDLE
        do_reset();
        drive(0, 0, 1, 1, 32'h8000_1000);
        cyc();
        drive(0, 0, 0, 1, 32'h8000_3000);
        out_chk("pend_new", 5'b00000, 5'b00011, 1, 32'h8000_3000);
        cyc();
        drive(0, 0, 0, 0, 0);
        out_chk("pend_new_after", 5'b0, 5'b0, 0, 0);

        // reset while pending discards the redirect
        do_reset();
        drive(0, 0, 1, 1, 32'h8000_4000);
        cyc();
        drive(0, 0, 0, 0, 0);
        rst_n = 1'b0;
        #1;
        chk("rst_pend.async", 64'(pc_redirect), 0);
        rst_n = 1'b1;
        #1;
        out_chk("rst_pend", 5'b0, 5'b0, 0, 0);

        // watchdog fires on the 8th consecutive stalled edge
        do_reset();
        drive(0, 1, 0, 0, 0);
        for (int i = 0; i < 7; i++) cyc();
        chk("tmo_7", 64'(stall_timeout), 0);
        cyc();
        chk("tmo_8", 64'(stall_timeout), 1);
        drive(0, 0, 0, 0, 0);
        cyc();
        cyc();
        chk("tmo_sticky", 64'(stall_timeout), 1);

        // 7-cycle bursts split by a free cycle never fire
        do_reset();
        for (int b = 0; b < 3; b++) begin
            drive(0, 1, 0, 0, 0);
            for (int i = 0; i < 7; i++) cyc();
            drive(0, 0, 0, 0, 0);
            cyc();
        end
        chk("tmo_bursts", 64'(stall_timeout), 0);

        // performance counters: 10 stall cycles + 2 redirects
        do_reset();
        drive(0, 1, 0, 0, 0);
        for (int i = 0; i < 10; i++) cyc();
        drive(0, 0, 0, 1, 32'h8000_0100);
        cyc();
        drive(0, 0, 0, 0, 0);
        cyc();
        drive(0, 0, 0, 1, 32'h8000_0200);
        cyc();
        drive(0, 0, 0, 0, 0);
        cyc();
`ifdef HAZARD_PERF_EN
        chk("perf_stall", 64'(perf_stall_cnt), 10);
        chk("perf_flush", 64'(perf_flush_cnt), 2);
`else
        chk("perf_stall", 64'(perf_stall_cnt), 0);
        chk("perf_flush", 64'(perf_flush_cnt), 0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
